// File: rtl/cordic_pkg.sv
// Shared constants and arctangent table for the CORDIC vectoring pipeline.
package cordic_pkg;

  localparam int unsigned ATAN_W = 32;
  localparam int unsigned ATAN_N = 24;

  // Inverse CORDIC gain 0.607253 in Q0.16, used as a 17-bit unsigned operand.
  localparam logic [15:0] KGAIN = 16'h9B74;

  // 180 degrees in Q.16 degree units.
  localparam int PHASE_180 = 180 * 65536;

  typedef logic [ATAN_N-1:0][ATAN_W-1:0] atan_tab_t;

  // atan(2^-i) in degrees scaled by 2^16, rounded to nearest.
  function automatic logic [ATAN_W-1:0] atan_deg_q16(input int unsigned i);
    real r;
    r = $atan(1.0 / (2.0 ** i)) * 180.0 / 3.14159265358979323846 * 65536.0;
    return ATAN_W'(longint'(r));
  endfunction

  // Elaboration-time table of all micro-rotation angles.
  function automatic atan_tab_t build_atan_tab();
    atan_tab_t t;
    for (int unsigned i = 0; i < ATAN_N; i++) begin
      t[i] = atan_deg_q16(i);
    end
    return t;
  endfunction

  localparam atan_tab_t ATAN_TAB = build_atan_tab();

endpackage

// File: rtl/cordic_vec_stage.sv
// One registered CORDIC vectoring micro-rotation; carries valid and zero flag.
module cordic_vec_stage #(
  parameter int unsigned            XW    = 34,
  parameter int unsigned            PW    = 32,
  parameter int unsigned            SHIFT = 0,
  parameter logic signed [PW-1:0]   ATAN  = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_valid,
  input  logic                 i_zero,
  input  logic signed [XW-1:0] i_x,
  input  logic signed [XW-1:0] i_y,
  input  logic signed [PW-1:0] i_z,
  output logic                 o_valid,
  output logic                 o_zero,
  output logic signed [XW-1:0] o_x,
  output logic signed [XW-1:0] o_y,
  output logic signed [PW-1:0] o_z
);

  logic                 r_valid;
  logic                 r_zero;
  logic signed [XW-1:0] r_x;
  logic signed [XW-1:0] r_y;
  logic signed [PW-1:0] r_z;

  logic                 w_d;
  logic signed [XW-1:0] w_xs;
  logic signed [XW-1:0] w_ys;

  assign w_d  = ~i_y[XW-1];
  assign w_xs = i_x >>> SHIFT;
  assign w_ys = i_y >>> SHIFT;

  // Rotate toward Y=0; data only advances with a valid sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_zero  <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
    end else begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_zero <= i_zero;
        if (w_d) begin
          r_x <= i_x + w_ys;
          r_y <= i_y - w_xs;
          r_z <= i_z + ATAN;
        end else begin
          r_x <= i_x - w_ys;
          r_y <= i_y + w_xs;
          r_z <= i_z - ATAN;
        end
      end
    end
  end

  assign o_valid = r_valid;
  assign o_zero  = r_zero;
  assign o_x     = r_x;
  assign o_y     = r_y;
  assign o_z     = r_z;

endmodule

// File: rtl/cordic_atan2_pipe.sv
// Fully pipelined full-circle atan2 / magnitude CORDIC vectoring engine.
module cordic_atan2_pipe
  import cordic_pkg::*;
#(
  parameter int unsigned DW  = 32,
  parameter int unsigned STG = 16,
  parameter int unsigned PW  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] x,
  input  logic signed [DW-1:0] y,
  output logic                 out_valid,
  output logic signed [PW-1:0] phase,
  output logic [DW:0]          mag
);

  localparam int unsigned XW    = DW + 2;
  localparam int unsigned PRODW = XW + 16;
  localparam logic signed [PW-1:0] P180 = PW'(PHASE_180);

  logic                 w_valid [STG+1];
  logic                 w_zero  [STG+1];
  logic signed [XW-1:0] w_x     [STG+1];
  logic signed [XW-1:0] w_y     [STG];
  logic signed [PW-1:0] w_z     [STG+1];

  logic signed [XW-1:0] w_xe;
  logic signed [XW-1:0] w_ye;

  logic                 r_p_valid;
  logic                 r_p_zero;
  logic signed [XW-1:0] r_p_x;
  logic signed [XW-1:0] r_p_y;
  logic signed [PW-1:0] r_p_z;

  assign w_xe = XW'(x);
  assign w_ye = XW'(y);

  // Pre-rotation: fold the left half-plane onto the right, seeding Z with +/-180.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p_valid <= 1'b0;
      r_p_zero  <= 1'b0;
      r_p_x     <= '0;
      r_p_y     <= '0;
      r_p_z     <= '0;
    end else begin
      r_p_valid <= in_valid;
      if (in_valid) begin
        r_p_zero <= (x == '0) && (y == '0);
        if (x[DW-1]) begin
          r_p_x <= -w_xe;
          r_p_y <= -w_ye;
          r_p_z <= y[DW-1] ? -P180 : P180;
        end else begin
          r_p_x <= w_xe;
          r_p_y <= w_ye;
          r_p_z <= '0;
        end
      end
    end
  end

  assign w_valid[0] = r_p_valid;
  assign w_zero[0]  = r_p_zero;
  assign w_x[0]     = r_p_x;
  assign w_y[0]     = r_p_y;
  assign w_z[0]     = r_p_z;

  for (genvar g = 0; g < STG; g++) begin : g_stage
    if (g == STG - 1) begin : g_last
      // Final stage: residual Y is not needed downstream.
      cordic_vec_stage #(
        .XW(XW), .PW(PW), .SHIFT(g), .ATAN(PW'(ATAN_TAB[g]))
      ) u_stage (
        .clk(clk), .rst_n(rst_n),
        .i_valid(w_valid[g]), .i_zero(w_zero[g]),
        .i_x(w_x[g]), .i_y(w_y[g]), .i_z(w_z[g]),
        .o_valid(w_valid[g+1]), .o_zero(w_zero[g+1]),
        .o_x(w_x[g+1]), .o_y(), .o_z(w_z[g+1])
      );
    end else begin : g_mid
      cordic_vec_stage #(
        .XW(XW), .PW(PW), .SHIFT(g), .ATAN(PW'(ATAN_TAB[g]))
      ) u_stage (
        .clk(clk), .rst_n(rst_n),
        .i_valid(w_valid[g]), .i_zero(w_zero[g]),
        .i_x(w_x[g]), .i_y(w_y[g]), .i_z(w_z[g]),
        .o_valid(w_valid[g+1]), .o_zero(w_zero[g+1]),
        .o_x(w_x[g+1]), .o_y(w_y[g+1]), .o_z(w_z[g+1])
      );
    end
  end

  logic [XW-2:0]        w_xu;
  logic [PRODW-1:0]     w_prod;
  logic [XW-1:0]        w_scaled;
  logic [DW:0]          w_mag_c;
  logic signed [PW-1:0] w_phase_c;

  // Gain removal with saturation; phase folds -180 onto +180.
  assign w_xu      = w_x[STG][XW-1] ? '0 : w_x[STG][XW-2:0];
  assign w_prod    = PRODW'(w_xu) * PRODW'(KGAIN);
  assign w_scaled  = XW'(w_prod >> 16);
  assign w_mag_c   = w_scaled[XW-1] ? '1 : w_scaled[DW:0];
  assign w_phase_c = w_zero[STG] ? '0 :
                     ((w_z[STG] == -P180) ? P180 : w_z[STG]);

  logic                 r_out_valid;
  logic signed [PW-1:0] r_phase;
  logic [DW:0]          r_mag;

  // Output stage: results update only with a valid sample, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_phase     <= '0;
      r_mag       <= '0;
    end else begin
      r_out_valid <= w_valid[STG];
      if (w_valid[STG]) begin
        r_phase <= w_phase_c;
        r_mag   <= w_zero[STG] ? '0 : w_mag_c;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign phase     = r_phase;
  assign mag       = r_mag;

endmodule

// File: tb/tb_cordic_atan2_pipe.sv
// Self-checking bench for cordic_atan2_pipe: directed table, random stream, reset.
module tb_cordic_atan2_pipe;

  localparam int unsigned DW  = 32;
  localparam int unsigned STG = 16;
  localparam int unsigned PW  = 32;
  localparam int          LAT = STG + 2;
  localparam longint      P360 = 360 * 65536;
  // 2*round(atan(2^-15) deg * 2^16) + STG = 2*115 + 16
  localparam longint      PTOL = 246;
  localparam real         PI   = 3.14159265358979323846;
  localparam int          NV   = 10;

  logic                 clk      = 1'b0;
  logic                 rst_n    = 1'b0;
  logic                 in_valid = 1'b0;
  logic signed [DW-1:0] x        = '0;
  logic signed [DW-1:0] y        = '0;
  logic                 out_valid;
  logic signed [PW-1:0] phase;
  logic [DW:0]          mag;

  always #5 clk = ~clk;

  cordic_atan2_pipe #(.DW(DW), .STG(STG), .PW(PW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .x(x), .y(y),
    .out_valid(out_valid), .phase(phase), .mag(mag)
  );

  typedef struct packed {
    logic              vld;
    logic              zero;
    logic signed [1:0] sgn;
    longint            ph;
    longint            mg;
    longint            mtol;
  } exp_t;

  typedef struct {
    int     vx;
    int     vy;
    longint ph;
    longint mg;
    logic   zero;
    int     sgn;
  } vec_t;

  exp_t q[$];
  exp_t last;
  vec_t tab [NV];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic longint mtol_of(input longint m);
    return longint'(real'(m) * 2.0e-4) + 2;
  endfunction

  // Real-valued atan2 / hypot reference.
  function automatic exp_t make_exp(input logic signed [31:0] xi, input logic signed [31:0] yi);
    exp_t e;
    real  rx, ry;
    rx     = real'(xi);
    ry     = real'(yi);
    e      = '0;
    e.vld  = 1'b1;
    e.zero = (xi == 0) && (yi == 0);
    e.ph   = longint'($atan2(ry, rx) * 180.0 / PI * 65536.0);
    e.mg   = longint'($sqrt(rx * rx + ry * ry));
    e.mtol = mtol_of(e.mg);
    return e;
  endfunction

  function automatic exp_t from_tab(input vec_t v);
    exp_t e;
    e      = '0;
    e.vld  = 1'b1;
    e.zero = v.zero;
    e.sgn  = 2'(v.sgn);
    e.ph   = v.ph;
    e.mg   = v.mg;
    e.mtol = mtol_of(v.mg);
    return e;
  endfunction

  function automatic logic signed [31:0] rnd();
    logic [31:0] m;
    if ($urandom_range(0, 999) == 0) return 32'sh8000_0000;
    m = $urandom_range(32'h7FFF_FFFF, 32'h0100_0000);
    return ($urandom_range(0, 1) == 1) ? -$signed(m) : $signed(m);
  endfunction

  task automatic chk(input string nm, input logic ok, input longint act, input longint req);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, req);
    end
  endtask

  task automatic cmp_data(input exp_t e);
    longint d;
    if (e.zero) begin
      chk("phase_zero", phase === '0, longint'(phase), 0);
      chk("mag_zero", mag === '0, longint'(mag), 0);
    end else begin
      d = longint'(phase) - e.ph;
      if (d > P360 / 2) d -= P360;
      if (d < -P360 / 2) d += P360;
      chk("phase", (d <= PTOL) && (d >= -PTOL), longint'(phase), e.ph);
      d = longint'(mag) - e.mg;
      chk("mag", (d <= e.mtol) && (d >= -e.mtol), longint'(mag), e.mg);
      if (e.sgn > 0) chk("phase_positive", phase > 0, longint'(phase), e.ph);
      if (e.sgn < 0) chk("phase_negative", phase < 0, longint'(phase), e.ph);
    end
  endtask

  // Compare outputs with the sample that entered LAT cycles ago (or the held one).
  task automatic check_out();
    exp_t f;
    f = '0;
    if (q.size() == LAT) f = q.pop_front();
    chk("out_valid", out_valid === f.vld, longint'(out_valid), longint'(f.vld));
    if (f.vld) last = f;
    cmp_data(last);
  endtask

  task automatic step_body(input logic v, input logic signed [31:0] xi,
                           input logic signed [31:0] yi, input exp_t e);
    check_out();
    in_valid = v;
    x        = xi;
    y        = yi;
    e.vld    = v;
    q.push_back(e);
  endtask

  task automatic step(input logic v, input logic signed [31:0] xi,
                      input logic signed [31:0] yi, input exp_t e);
    @(negedge clk);
    step_body(v, xi, yi, e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, $urandom, $urandom, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    q.delete();
    last      = '0;
    last.zero = 1'b1;
    check_out();
    @(negedge clk);
    rst_n = 1'b1;
    step_body(1'b0, '0, '0, '0);
  endtask

  initial begin
    logic signed [31:0] rx, ry;
    int                 n;

    tab[0] = '{65536, 65536, 2949120, 92682, 1'b0, 0};
    tab[1] = '{-65536, 0, 11796480, 65536, 1'b0, 1};
    tab[2] = '{0, -65536, -5898240, 65536, 1'b0, 0};
    tab[3] = '{-65536, -1, -11796423, 65536, 1'b0, -1};
    tab[4] = '{0, 0, 0, 0, 1'b1, 0};
    tab[5] = '{-2147483647 - 1, -2147483647 - 1, -8847360, 64'd3037000500, 1'b0, 0};
    tab[6] = '{0, 65536, 5898240, 65536, 1'b0, 0};
    tab[7] = '{-65536, 65536, 8847360, 92682, 1'b0, 0};
    tab[8] = '{65536, -65536, -2949120, 92682, 1'b0, 0};
    tab[9] = '{1048576, 0, 0, 1048576, 1'b0, 0};

    last      = '0;
    last.zero = 1'b1;
    repeat (3) @(negedge clk);
    check_out();
    rst_n = 1'b1;

    // Directed vectors as isolated pulses.
    for (int i = 0; i < NV; i++) begin
      step(1'b1, tab[i].vx, tab[i].vy, from_tab(tab[i]));
      idle(LAT + 1);
    end
    // Same vectors back to back.
    for (int i = 0; i < NV; i++) step(1'b1, tab[i].vx, tab[i].vy, from_tab(tab[i]));
    idle(LAT + 2);

    // Random stream with random gaps.
    n = 0;
    while (n < 10000) begin
      if ($urandom_range(0, 3) == 0) begin
        idle(1);
      end else begin
        rx = rnd();
        ry = rnd();
        step(1'b1, rx, ry, make_exp(rx, ry));
        n++;
      end
    end
    idle(LAT + 2);

    // Reset with ten samples in flight: none may emerge.
    for (int i = 0; i < 10; i++) begin
      rx = rnd();
      ry = rnd();
      step(1'b1, rx, ry, make_exp(rx, ry));
    end
    do_reset();
    idle(LAT + 4);
    step(1'b1, 32'sd65536, 32'sd65536, make_exp(32'sd65536, 32'sd65536));
    idle(LAT + 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cordic_atan2_pipe.md
# cordic_atan2_pipe

Fully pipelined, parametrised CORDIC vectoring engine that computes phase = atan2(y, x) over the full circle and the gain-compensated magnitude sqrt(x²+y²) of a signed input vector. It is the next-generation replacement for the fixed 32-bit, first/fourth-quadrant-only vectoring core. It adds a valid pipeline, quadrant pre-rotation, magnitude output and reset. It sits between the front-end sample path and the phase/amplitude consumers, and accepts one sample per clock.

## Interface
- DW, 32: input width; x, y are signed two's complement.
- STG, 16: micro-rotation stages; legal range 4..24.
- PW, 32: phase width; signed degrees in Q(PW-16).16 format.
- clk  in  1  sole clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  x/y qualifier; sampled every cycle; no backpressure.
- x  in  DW  signed X component.
- y  in  DW  signed Y component.
- out_valid  out  1  phase/mag qualifier.
- phase  out  PW  signed; degrees×2^16; range (-180, +180].
- mag  out  DW+1  unsigned magnitude in input LSBs, CORDIC gain removed.

## Operation
- Internal X/Y width is DW+2 signed, which absorbs CORDIC growth of 1.647×√2. Z is PW signed. All shifts are arithmetic (>>>).
- Stage P (pre-rotation), registered:
  - If x<0: X=-x, Y=-y, Z = (y>=0) ? +180·2^16 : -180·2^16.
  - Else: X=x, Y=y, Z=0.
  - Negation is done at DW+2 width, so x=-2^(DW-1) does not overflow.
- Stages i=0..STG-1, registered, with d = (Y[i] >= 0):
  - d=1: X+=Y>>>i, Y-=X>>>i, Z+=ATAN[i].
  - d=0: X-=Y>>>i, Y+=X>>>i, Z-=ATAN[i].
- ATAN[i] = round(atan(2^-i)·180/π·2^16) to nearest, e.g. ATAN[0]=2949120 and ATAN[1]=1740967. The table is generated by a package function, not hand-typed.
- Stage G (gain), registered:
  - mag = (X_final · KGAIN) >>> 16, where KGAIN = 16'h9B74 (0.607253·2^16), 17-bit unsigned multiply.
  - Result is saturated to DW+1 bits.
  - phase = Z_final.
- Zero vector: a flag (x==0 && y==0) rides the valid pipeline. When set, stage G forces phase=0 and mag=0.
- Phase wrap: if Z_final = -180·2^16 exactly, output +180·2^16. The range is half-open, (-180, +180].
- Data registers of a stage load only when that stage's valid bit is 1. When out_valid=0, phase and mag hold their last value.

## Timing
- Latency: STG+2 cycles from in_valid=1 at edge n to out_valid=1 after edge n+STG+2. For STG=16 this is 18.
- Throughput: 1 sample/cycle. in_valid gaps propagate unchanged, so the out_valid pattern equals the in_valid pattern delayed by STG+2.
- Reset value of every output: out_valid=0, phase=0, mag=0. All valid bits and data registers clear asynchronously.
- Reset mid-operation: all in-flight samples are discarded and never appear. out_valid stays 0 until STG+2 cycles after the first in_valid following rst_n release.
- Accuracy, for |x|,|y| ≥ 2^10 and STG=16:
  - |phase error| ≤ 2·ATAN[STG-1] + STG LSB.
  - mag relative error ≤ 0.02% + 2 LSB.

## Structure
- Package cordic_pkg holds:
  - atan_deg_q16(i) function, plus the ATAN table built from it for up to 24 entries.
  - KGAIN constant.
  - PHASE_180 = 180·2^16 constant.
- Sub-module cordic_vec_stage (params: DW+2, PW, SHIFT, ATAN value) is one registered micro-rotation carrying valid and the zero flag.
- Top level: generate-loop of STG instances, plus pre-rotation and gain stages inline.

## Test plan
- x=65536, y=65536, single pulse → out_valid exactly 18 cycles later; phase=2949120±tol; mag=92682±2.
- x=-65536, y=0 → phase=+11796480 (+180°, never -180°); mag=65536±2.
- x=0, y=-65536 → phase=-5898240±tol (-90°); x=-65536, y=-1 → phase ≈ -180°+ε, negative.
- x=0, y=0 → phase=0, mag=0 exactly; x=-2^31, y=-2^31 → mag=3037000499±0.02%, no wrap.
- Random stream of 10k vectors with random in_valid gaps vs a real-valued atan2/hypot model → all within tolerance; out_valid pattern equals in_valid delayed by 18.
- rst_n pulsed low for 1 cycle mid-stream with 10 samples in flight → outputs 0 immediately; none of the 10 samples emerges; next sample appears 18 cycles after its in_valid.
